// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             x, y, bin;
  logic             d_bit, b_next;
  logic [WIDTH-1:0] res_sh;

  // One full-subtractor cell on the current LSBs
  always_comb begin
    x      = a_sr_q[0];
    y      = b_sr_q[0];
    bin    = borrow_q;
    d_bit  = x ^ y ^ bin;
    b_next = (~x & y) | (~(x ^ y) & bin);
    res_sh = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          count_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d   = a[WIDTH-1];
          bmsb_d   = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        res_d    = res_sh;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = b_next;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
          diff_d  = res_sh;
          bout_d  = b_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == DONE);
    busy_d  = (state_d == SHIFT);
    ready_d = (state_d != SHIFT);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed runs, WIDTH=4 sweep.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, done4, bout4;
  logic [3:0] diff4;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb8[$];
  exp_t sb4[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4),
    .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] av,
                                  input logic [7:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bo = (av < bv);
    e.ov = (av[7] != bv[7]) && (e.d[7] != av[7]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inj >= 0: drive a stray start (0x10 - 0x01) at that shift cycle
  task automatic run8(input logic [7:0] av,
                      input logic [7:0] bv,
                      input int inj,
                      input string tag);
    exp_t       e;
    int         lat, busy_n, g;
    logic [7:0] prev;
    logic       hold_ok;
    g = 0;
    while (!ready8 && g < 50) begin
      tick();
      g++;
    end
    sb8.push_back(model8(av, bv));
    prev   = diff8;
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    tick();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    lat     = 0;
    busy_n  = 0;
    hold_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (busy8) busy_n++;
      if (diff8 !== prev) hold_ok = 1'b0;
      tick();
      lat++;
      if (lat == inj) begin
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h01;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_busy"}, busy_n, 8);
    chk({tag, "_hold"}, 32'(hold_ok), 1);
    chk({tag, "_ready"}, 32'(ready8), 1);
    e = sb8.pop_front();
    chk({tag, "_diff"}, 32'(diff8), 32'(e.d));
    chk({tag, "_bout"}, 32'(bout8), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf8), 32'(e.ov));
`endif
    tick();
    chk({tag, "_pulse"}, 32'(done8), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e4;
    int   lat, idx, seen;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(ready8), 1);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bout8), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf8), 0);
`endif
    rst = 1'b0;
    tick();

    // Directed operands
    run8(8'h05, 8'h03, -1, "p05_03");
    run8(8'h03, 8'h05, -1, "p03_05");
    run8(8'h00, 8'h00, -1, "p00_00");
    run8(8'hFF, 8'hFF, -1, "pFF_FF");
    run8(8'hA5, 8'h5A, -1, "pA5_5A");
`ifdef SERIAL_SUB_OVF_EN
    run8(8'h80, 8'h01, -1, "ovf80_01");
    run8(8'h7F, 8'hFF, -1, "ovf7F_FF");
    run8(8'h05, 8'h03, -1, "ovf05_03");
`endif

    // Start while busy is ignored
    run8(8'h20, 8'h07, 3, "ign");

    // Reset three cycles into SHIFT
    start8 = 1'b1;
    a8     = 8'h40;
    b8     = 8'h11;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", 32'(busy8), 1);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready8), 1);
    chk("mrst_busy", 32'(busy8), 0);
    chk("mrst_done", 32'(done8), 0);
    chk("mrst_diff", 32'(diff8), 0);
    chk("mrst_bout", 32'(bout8), 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) seen++;
    end
    chk("mrst_nodone", seen, 0);
    run8(8'h40, 8'h11, -1, "post_rst");

    // WIDTH=4 exhaustive sweep, back-to-back starts in DONE
    start4 = 1'b1;
    a4     = 4'd0;
    b4     = 4'd0;
    for (idx = 0; idx < 256; idx++) begin
      e4.d  = 8'((a4 - b4) & 4'hF);
      e4.bo = (a4 < b4);
      e4.ov = (a4[3] != b4[3]) && (e4.d[3] != a4[3]);
      sb4.push_back(e4);
      tick();
      start4 = 1'b0;
      lat    = 0;
      while (!done4 && lat < 20) begin
        tick();
        lat++;
      end
      chk("sw_lat", lat, 4);
      e4 = sb4.pop_front();
      chk("sw_diff", 32'(diff4), 32'(e4.d));
      chk("sw_bout", 32'(bout4), 32'(e4.bo));
`ifdef SERIAL_SUB_OVF_EN
      chk("sw_ovf", 32'(ovf4), 32'(e4.ov));
`endif
      if (idx < 255) begin
        start4 = 1'b1;
        a4     = 4'((idx + 1) >> 4);
        b4     = 4'((idx + 1) & 15);
      end
    end
    tick();
    chk("sw_idle", 32'(ready4), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
